// File: rtl/pedidos_pkg.sv
// Shared definitions for the cargo request queue: default floor geometry,
// the request record and the head-phase encoding.
package pedidos_pkg;

    localparam int DEF_NUM_ANDARES   = 4;
    localparam int DEF_ANDAR_W       = 2;
    localparam int DEF_PROFUNDIDADE  = 8;
    localparam int DEF_PTR_W         = 3;

    typedef struct packed {
        logic [DEF_ANDAR_W-1:0] origem;
        logic [DEF_ANDAR_W-1:0] destino;
    } pedido_t;

    typedef enum logic [1:0] {
        VAZIA   = 2'b00,
        ORIGEM  = 2'b01,
        DESTINO = 2'b10
    } fase_e;

endpackage

// File: rtl/fifo_circular.sv
// Circular register-array FIFO with head/tail pointers and an occupancy count.
// Push is refused when full (pre-pop); pop is refused when empty; clear wins.
module fifo_circular #(
    parameter int LARGURA      = 4,
    parameter int PROFUNDIDADE = 8,
    parameter int PTR_W        = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] din,
    output logic [LARGURA-1:0] dout,
    output logic [PTR_W:0]     ocupacao,
    output logic               cheia
);

    localparam logic [PTR_W:0] PROF_L = (PTR_W+1)'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     ocup_q, ocup_d;
    logic               vazia;
    logic               push_ok;
    logic               pop_ok;

    assign cheia    = (ocup_q == PROF_L);
    assign vazia    = (ocup_q == '0);
    assign push_ok  = push && !cheia && !clear;
    assign pop_ok   = pop && !vazia && !clear;
    assign dout     = mem_q[head_q];
    assign ocupacao = ocup_q;

    // Pointers are PTR_W wide, so the increment wraps modulo the depth for free.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ocup_d = ocup_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            ocup_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            ocup_d = ocup_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            ocup_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ocup_q <= ocup_d;
        end
    end

    // NOTE: the storage array has no reset; ocupacao alone says which slots are
    // valid, which keeps the array a plain register file.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[tail_q] <= din;
    end

endmodule

// File: rtl/fila_pedidos.sv
// Request queue feeding uc_movimento: validates pushes, tracks origin/destination
// phase of the head request and decodes stop outputs. Optional macro FILA_DEDUP_EN.
module fila_pedidos
    import pedidos_pkg::*;
#(
    parameter int NUM_ANDARES  = DEF_NUM_ANDARES,
    parameter int ANDAR_W      = DEF_ANDAR_W,
    parameter int PROFUNDIDADE = DEF_PROFUNDIDADE,
    parameter int PTR_W        = DEF_PTR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clearFila,
    input  logic               novoPedido,
    input  logic [ANDAR_W-1:0] origemPedido,
    input  logic [ANDAR_W-1:0] destinoPedido,
    input  logic               shift,
    input  logic [ANDAR_W-1:0] andarAtual,
    output logic               temDestino,
    output logic               sobe,
    output logic               chegouDestino,
    output logic               eh_origem,
    output logic [ANDAR_W-1:0] destinoAtual,
    output logic               filaCheia,
    output logic [PTR_W:0]     ocupacao,
    output logic               pedidoRejeitado
);

    localparam logic [ANDAR_W:0] LIMITE = (ANDAR_W+1)'(NUM_ANDARES);
    localparam logic [PTR_W:0]   UM     = (PTR_W+1)'(1);

    typedef struct packed {
        logic [ANDAR_W-1:0] origem;
        logic [ANDAR_W-1:0] destino;
    } pedido_w_t;

    pedido_w_t      novo;
    pedido_w_t      cabeca;
    fase_e          estado_q, estado_d;
    logic           rejeitado_q, rejeitado_d;
    logic           cheia;
    logic [PTR_W:0] ocup;
    logic           andares_ok;
    logic           duplicado;
    logic           push;
    logic           pop;

    assign novo       = {origemPedido, destinoPedido};
    assign andares_ok = ({1'b0, origemPedido} < LIMITE) && ({1'b0, destinoPedido} < LIMITE)
                        && (origemPedido != destinoPedido);
    assign push       = novoPedido && andares_ok && !cheia && !duplicado;
    assign pop        = shift && (estado_q == DESTINO);

    fifo_circular #(
        .LARGURA      (2*ANDAR_W),
        .PROFUNDIDADE (PROFUNDIDADE),
        .PTR_W        (PTR_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clearFila),
        .push     (push),
        .pop      (pop),
        .din      (novo),
        .dout     (cabeca),
        .ocupacao (ocup),
        .cheia    (cheia)
    );

`ifdef FILA_DEDUP_EN
    pedido_w_t ultimo_q, ultimo_d;
    logic      ultimo_vld_q, ultimo_vld_d;
    logic      esvazia;

    // The newest entry leaves the queue only when it is also the last one.
    assign esvazia   = pop && (ocup == UM);
    assign duplicado = ultimo_vld_q && (novo == ultimo_q) && !esvazia;

    always_comb begin
        ultimo_d     = ultimo_q;
        ultimo_vld_d = ultimo_vld_q;
        if (clearFila) begin
            ultimo_vld_d = 1'b0;
        end else if (push) begin
            ultimo_d     = novo;
            ultimo_vld_d = 1'b1;
        end else if (esvazia) begin
            ultimo_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ultimo_q     <= '0;
            ultimo_vld_q <= 1'b0;
        end else begin
            ultimo_q     <= ultimo_d;
            ultimo_vld_q <= ultimo_vld_d;
        end
    end
`else
    assign duplicado = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        estado_d    = estado_q;
        rejeitado_d = novoPedido && !push;
        if (clearFila) begin
            estado_d    = VAZIA;
            rejeitado_d = 1'b0;
        end else begin
            unique case (estado_q)
                VAZIA:   if (push)  estado_d = ORIGEM;
                ORIGEM:  if (shift) estado_d = DESTINO;
                DESTINO: if (shift) estado_d = ((ocup > UM) || push) ? ORIGEM : VAZIA;
                default: estado_d = VAZIA;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= VAZIA;
            rejeitado_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            rejeitado_q <= rejeitado_d;
        end
    end

    always_comb begin
        destinoAtual = '0;
        case (estado_q)
            ORIGEM:  destinoAtual = cabeca.origem;
            DESTINO: destinoAtual = cabeca.destino;
            default: destinoAtual = '0;
        endcase
    end

    assign temDestino      = (estado_q != VAZIA);
    assign eh_origem       = (estado_q == ORIGEM);
    assign sobe            = temDestino && (destinoAtual > andarAtual);
    assign chegouDestino   = temDestino && (destinoAtual == andarAtual);
    assign filaCheia       = cheia;
    assign ocupacao        = ocup;
    assign pedidoRejeitado = rejeitado_q;

endmodule
